// File: rtl/axis_frame_packer.sv
// Round-robin packer: one channel word + {ch, seq} header becomes NBEATS AXIS beats, beat 0 one cycle after accept.
// Stalls on m_axis_c2h_tready; s_ready stays low until the frame in flight has gone out.
module axis_frame_packer #(
    parameter int DATA_WIDTH      = 4064,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int NUM_CH          = 2,
    parameter int SEQ_WIDTH       = 8,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int KEEP_W         = AXIS_DATA_WIDTH / 8
) (
    input  logic                         m_axis_c2h_aclk,
    input  logic                         m_axis_c2h_areset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]            s_valid,
    output logic [NUM_CH-1:0]            s_ready,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_c2h_tdata,
    output logic [KEEP_W-1:0]            m_axis_c2h_tkeep,
    output logic                         m_axis_c2h_tlast,
    output logic                         m_axis_c2h_tvalid,
    input  logic                         m_axis_c2h_tready,
    output logic                         busy,
    output logic [CH_W-1:0]              cur_ch,
    output logic [31:0]                  frame_cnt
);

    localparam int HDR_W      = SEQ_WIDTH + CH_W;
    localparam int FRAME_W    = HDR_W + DATA_WIDTH;
    localparam int NBEATS     = (FRAME_W + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
    localparam int SR_W       = NBEATS * AXIS_DATA_WIDTH;
    localparam int LAST_BYTES = (FRAME_W - (NBEATS - 1) * AXIS_DATA_WIDTH + 7) / 8;
    localparam int BIDX_W     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [KEEP_W-1:0] KEEP_LAST = {KEEP_W{1'b1}} >> (KEEP_W - LAST_BYTES);
    localparam logic [BIDX_W-1:0] LAST_IDX  = BIDX_W'(NBEATS - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t                     state_q, state_d;
    logic [SR_W-1:0]            sr_q, sr_d;
    logic [BIDX_W-1:0]          beat_q, beat_d;
    logic [CH_W-1:0]            rr_q, rr_d;
    logic [CH_W-1:0]            cur_q, cur_d;
    logic [NUM_CH*SEQ_WIDTH-1:0] seq_q, seq_d;
    logic [31:0]                cnt_q, cnt_d;

    logic                       grant_vld;
    logic [CH_W-1:0]            grant;
    logic [CH_W-1:0]            scan_idx;
    logic [SR_W-1:0]            frame;
    logic                       last_beat;

    // First valid channel at or above rr_q, wrapping modulo NUM_CH.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            scan_idx = CH_W'((int'(rr_q) + i) % NUM_CH);
            if (!grant_vld && s_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant     = scan_idx;
            end
        end
    end

    always_comb begin
        frame                         = '0;
        frame[SEQ_WIDTH-1:0]          = seq_q[int'(grant)*SEQ_WIDTH +: SEQ_WIDTH];
        frame[HDR_W-1:SEQ_WIDTH]      = grant;
        frame[HDR_W +: DATA_WIDTH]    = s_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        s_ready = '0;
        if (state_q == ST_IDLE && grant_vld && !m_axis_c2h_areset) begin
            s_ready[grant] = 1'b1;
        end
    end

    assign last_beat = (beat_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        beat_d  = beat_q;
        rr_d    = rr_q;
        cur_d   = cur_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    sr_d    = frame;
                    beat_d  = '0;
                    cur_d   = grant;
                    rr_d    = (int'(grant) == NUM_CH - 1) ? '0 : CH_W'(grant + 1'b1);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_c2h_tready) begin
                    if (!last_beat) begin
                        sr_d   = sr_q >> AXIS_DATA_WIDTH;
                        beat_d = beat_q + BIDX_W'(1);
                    end else begin
                        // Sequence advances only on a completed frame, so aborted frames reuse it.
                        seq_d[int'(cur_q)*SEQ_WIDTH +: SEQ_WIDTH] =
                            seq_q[int'(cur_q)*SEQ_WIDTH +: SEQ_WIDTH] + SEQ_WIDTH'(1);
                        cnt_d   = cnt_q + 32'd1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_axis_c2h_aclk) begin
        if (m_axis_c2h_areset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            beat_q  <= '0;
            rr_q    <= '0;
            cur_q   <= '0;
            seq_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            beat_q  <= beat_d;
            rr_q    <= rr_d;
            cur_q   <= cur_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m_axis_c2h_tvalid = (state_q == ST_SEND);
    assign busy              = (state_q == ST_SEND);
    assign m_axis_c2h_tdata  = sr_q[AXIS_DATA_WIDTH-1:0];
    assign m_axis_c2h_tlast  = (state_q == ST_SEND) && last_beat;
    assign m_axis_c2h_tkeep  = (state_q != ST_SEND) ? '0 : (last_beat ? KEEP_LAST : {KEEP_W{1'b1}});
    assign cur_ch            = cur_q;
    assign frame_cnt         = cnt_q;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer: default 2-channel instance plus a 1-channel, 1000-bit instance.
module tb_axis_frame_packer;

    localparam int DW = 4064;
    localparam int AW = 512;
    localparam int KW = 64;
    localparam int NB = 8;
    localparam logic [KW-1:0] KEEP_LAST8 = 64'h3FFF_FFFF_FFFF_FFFF;
    localparam logic [KW-1:0] KEEP_LAST2 = 64'h7FFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2*DW-1:0] s_data;
    logic [1:0]      s_valid, s_ready;
    logic [AW-1:0]   tdata;
    logic [KW-1:0]   tkeep;
    logic            tlast, tvalid, tready, busy;
    logic [0:0]      cur_ch;
    logic [31:0]     frame_cnt;

    logic [999:0]    sm_data;
    logic [0:0]      sm_valid, sm_ready;
    logic [AW-1:0]   sm_tdata;
    logic [KW-1:0]   sm_tkeep;
    logic            sm_tlast, sm_tvalid, sm_tready, sm_busy;
    logic [0:0]      sm_cur;
    logic [31:0]     sm_cnt;

    axis_frame_packer dut (
        .m_axis_c2h_aclk   (clk),
        .m_axis_c2h_areset (rst),
        .s_data            (s_data),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .m_axis_c2h_tdata  (tdata),
        .m_axis_c2h_tkeep  (tkeep),
        .m_axis_c2h_tlast  (tlast),
        .m_axis_c2h_tvalid (tvalid),
        .m_axis_c2h_tready (tready),
        .busy              (busy),
        .cur_ch            (cur_ch),
        .frame_cnt         (frame_cnt)
    );

    axis_frame_packer #(.DATA_WIDTH(1000), .NUM_CH(1)) dut_sm (
        .m_axis_c2h_aclk   (clk),
        .m_axis_c2h_areset (rst),
        .s_data            (sm_data),
        .s_valid           (sm_valid),
        .s_ready           (sm_ready),
        .m_axis_c2h_tdata  (sm_tdata),
        .m_axis_c2h_tkeep  (sm_tkeep),
        .m_axis_c2h_tlast  (sm_tlast),
        .m_axis_c2h_tvalid (sm_tvalid),
        .m_axis_c2h_tready (sm_tready),
        .busy              (sm_busy),
        .cur_ch            (sm_cur),
        .frame_cnt         (sm_cnt)
    );

    typedef struct {
        logic [1:0] vld;
        int         ch;
        int         seq;
        bit         rnd;
    } vec_t;

    int            checks   = 0;
    int            failures = 0;
    int            words[2];
    logic [AW-1:0] last_beat0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] make_word(input int c, input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < DW/8; i++) w[i*8 +: 8] = 8'((i + c*37 + n*11) % 256);
        return w;
    endfunction

    function automatic logic [999:0] make_small(input int n);
        logic [999:0] w;
        w = '0;
        for (int i = 0; i < 125; i++) w[i*8 +: 8] = 8'((i*3 + n*5 + 1) % 256);
        return w;
    endfunction

    task automatic drive_data(input int c);
        s_data[c*DW +: DW] = make_word(c, words[c]);
    endtask

    // Expects s_valid already driven; consumes one frame from exp_ch and checks every beat.
    task automatic do_frame(input int exp_ch, input int exp_seq, input bit rnd);
        logic [4095:0] f;
        logic [AW-1:0] hold_d;
        logic [KW-1:0] hold_k;
        logic          hold_l;
        logic [KW-1:0] exp_k;
        logic [1:0]    exp_rdy;
        bit            holding;
        int            beats, cycles, waited;
        f = '0;
        f[7:0] = 8'(exp_seq);
        f[8] = 1'(exp_ch);
        f[9 +: DW] = make_word(exp_ch, words[exp_ch]);
        exp_rdy = 2'(1 << exp_ch);
        #1;
        waited = 0;
        while (s_ready == 2'b00 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("grant", s_ready, exp_rdy);
        if (s_ready == 2'b00) return;
        beats = 0;
        cycles = 0;
        holding = 0;
        while (beats < NB && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                words[exp_ch]++;
                drive_data(exp_ch);
                chk("s_ready_in_send", s_ready, 0);
                chk("cur_ch", cur_ch, exp_ch);
                chk("busy_in_send", busy, 1);
            end
            if (!tvalid) begin
                chk("tvalid_mid_frame", tvalid, 1);
                break;
            end
            if (holding) begin
                chk("stall_tdata", tdata, hold_d);
                chk("stall_tkeep_tlast", {tkeep, tlast}, {hold_k, hold_l});
            end
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tready) begin
                exp_k = (beats == NB-1) ? KEEP_LAST8 : {KW{1'b1}};
                chk("beat_data", tdata, f[beats*AW +: AW]);
                chk("beat_tkeep", tkeep, exp_k);
                chk("beat_tlast", tlast, (beats == NB-1));
                if (beats == 0) last_beat0 = tdata;
                beats++;
                holding = 0;
            end else begin
                holding = 1;
                hold_d = tdata;
                hold_k = tkeep;
                hold_l = tlast;
            end
        end
        chk("beat_count", beats, NB);
        if (!rnd) chk("frame_cycles", cycles, NB);
        @(negedge clk);
        chk("busy_after_frame", busy, 0);
        chk("tvalid_after_frame", tvalid, 0);
    endtask

    initial begin
        vec_t tbl[8];
        logic [1023:0] fs;
        int waited;
        tbl[0] = '{2'b01, 0, 0, 1'b0};
        tbl[1] = '{2'b11, 1, 0, 1'b0};
        tbl[2] = '{2'b11, 0, 1, 1'b0};
        tbl[3] = '{2'b11, 1, 1, 1'b1};
        tbl[4] = '{2'b10, 1, 2, 1'b0};
        tbl[5] = '{2'b10, 1, 3, 1'b1};
        tbl[6] = '{2'b01, 0, 2, 1'b0};
        tbl[7] = '{2'b11, 1, 4, 1'b0};

        rst = 1'b1;
        tready = 1'b0;
        sm_tready = 1'b0;
        s_data = '0;
        words[0] = 0;
        words[1] = 0;
        drive_data(0);
        drive_data(1);
        s_valid = 2'b11;
        sm_valid = 1'b1;
        sm_data = make_small(0);
        repeat (3) @(negedge clk);

        chk("rst_s_ready", s_ready, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tkeep", tkeep, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_ch", cur_ch, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_sm_ready", sm_ready, 0);
        chk("rst_sm_tvalid", sm_tvalid, 0);
        s_valid = 2'b00;
        sm_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int e = 0; e < 8; e++) begin
            s_valid = tbl[e].vld;
            do_frame(tbl[e].ch, tbl[e].seq, tbl[e].rnd);
            if (e == 0) begin
                chk("beat0_header", last_beat0[8:0], 9'h000);
                chk("beat0_payload_lsb", last_beat0[24:9], 16'h0100);
            end
        end
        chk("frame_cnt_table", frame_cnt, 8);

        s_valid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            do_frame(i % 2, (i % 2 == 0) ? 3 + i/2 : 5 + i/2, 1'b1);
        end
        chk("frame_cnt_20", frame_cnt, 20);

        rst = 1'b1;
        s_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        chk("frame_cnt_after_rst", frame_cnt, 0);

        s_valid = 2'b10;
        for (int k = 0; k < 257; k++) do_frame(1, k % 256, 1'b0);
        s_valid = 2'b01;
        do_frame(0, 0, 1'b0);
        chk("frame_cnt_258", frame_cnt, 258);

        // Abort a frame while beat 3 is on the bus.
        s_valid = 2'b01;
        #1;
        waited = 0;
        while (s_ready == 2'b00 && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("abort_grant", s_ready, 2'b01);
        fs = '0;
        tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                words[0]++;
                drive_data(0);
            end
        end
        chk("abort_tvalid_before", tvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tvalid", tvalid, 0);
        chk("abort_tlast", tlast, 0);
        chk("abort_tkeep", tkeep, 0);
        chk("abort_tdata", tdata, 0);
        chk("abort_busy", busy, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_frame_cnt", frame_cnt, 0);
        rst = 1'b0;
        do_frame(0, 0, 1'b0);
        chk("frame_cnt_after_abort", frame_cnt, 1);
        s_valid = 2'b00;

        // Single-channel, 1000-bit instance: two beats, partial keep on the second.
        sm_valid = 1'b1;
        sm_tready = 1'b1;
        for (int fr = 0; fr < 2; fr++) begin
            fs = '0;
            fs[7:0] = 8'(fr);
            fs[8] = 1'b0;
            fs[9 +: 1000] = make_small(fr);
            #1;
            waited = 0;
            while (sm_ready == 1'b0 && waited < 50) begin
                @(negedge clk);
                #1;
                waited++;
            end
            chk("sm_grant", sm_ready, 1);
            @(negedge clk);
            sm_data = make_small(fr + 1);
            chk("sm_b0_tvalid", sm_tvalid, 1);
            chk("sm_b0_tdata", sm_tdata, fs[511:0]);
            chk("sm_b0_tkeep", sm_tkeep, {KW{1'b1}});
            chk("sm_b0_tlast", sm_tlast, 0);
            @(negedge clk);
            chk("sm_b1_tdata", sm_tdata, fs[1023:512]);
            chk("sm_b1_pad", sm_tdata[511:497], 15'h0);
            chk("sm_b1_tkeep", sm_tkeep, KEEP_LAST2);
            chk("sm_b1_tlast", sm_tlast, 1);
            @(negedge clk);
            chk("sm_busy_after", sm_busy, 0);
        end
        chk("sm_frame_cnt", sm_cnt, 2);
        sm_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
